// File: rtl/controller_rom_loader_pkg.sv
// Shared types and constants for the instruction-memory field-update loader.
// Optional readback check is enabled with CONTROLLER_ROM_LOADER_VERIFY_EN.
package controller_rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_VERIFY = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_HDR    = 2'd1;
    localparam logic [1:0] ERR_ABORT  = 2'd2;
    localparam logic [1:0] ERR_VERIFY = 2'd3;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // The end address is formed 17 bits wide so a header near the top cannot wrap into range.
    function automatic logic hdr_in_range(input logic [15:0] addr, input logic [15:0] count,
                                          input int depth);
        logic [16:0] end_v;
        end_v = {1'b0, addr} + {1'b0, count};
        return (count != 16'd0) && (end_v <= 17'(depth));
    endfunction

endpackage

// File: rtl/controller_rom_loader_if.sv
// Port-2 bus of the instruction memory; the loader is the master, the memory the slave.
interface controller_rom_loader_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] rom_address;
    logic              rom_chipselect;
    logic              rom_write;
    logic [3:0]        rom_byteenable;
    logic [31:0]       rom_writedata;
    logic [31:0]       rom_readdata;

    modport master (
        output rom_address, rom_chipselect, rom_write, rom_byteenable, rom_writedata,
        input  rom_readdata
    );

    modport slave (
        input  rom_address, rom_chipselect, rom_write, rom_byteenable, rom_writedata,
        output rom_readdata
    );
endinterface

// File: rtl/controller_rom_loader_packer.sv
// Little-endian byte-to-word packer, shared by the header and data phases.
module controller_rom_loader_packer
    import controller_rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic [31:0] word
);
    logic [1:0]  idx_r;
    logic [23:0] part_r;

    // Only three bytes are held; the arriving byte completes the word combinationally.
    assign word     = {byte_in, part_r};
    assign byte_idx = idx_r;

    // Byte position counter and partial-word shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r  <= 2'd0;
            part_r <= 24'd0;
        end else if (clr) begin
            idx_r  <= 2'd0;
            part_r <= 24'd0;
        end else if (en) begin
            part_r <= word[31:8];
            if (idx_r == 2'(WORD_BYTES - 1)) begin
                idx_r <= 2'd0;
            end else begin
                idx_r <= idx_r + 2'd1;
            end
        end
    end
endmodule

// File: rtl/controller_rom_loader.sv
// Framed byte-stream loader for port 2 of the instruction memory; holds the CPU in reset while loading.
// Define CONTROLLER_ROM_LOADER_VERIFY_EN to add a pipelined readback checksum check after the last write.
module controller_rom_loader
    import controller_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      abort,
    input  logic                      clear,
    controller_rom_loader_if.master   rom,
    output logic                      cpu_hold,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                err_code,
    output logic [31:0]               checksum
);
    state_e state_r, state_n;
    logic [1:0]  err_n_s;
    logic        accept_s, start_s, pk_clr_s, hdr_last_s, hdr_ok_s, data_last_s, cs_n_s;
    logic [1:0]  pk_idx_s;
    logic [31:0] pk_word_s;

    logic        s_ready_r, busy_r, done_r, cpu_hold_r, cs_r, wr_r;
    logic [1:0]  err_r;
    logic [3:0]  be_r;
    logic [31:0] checksum_r, wdata_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0] remain_r;

`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_r;
    logic [15:0] count_r, v_left_r;
    logic        rd_pend_r;
    logic [31:0] vsum_r, vsum_final_s;
    assign vsum_final_s = vsum_r + (rd_pend_r ? rom.rom_readdata : 32'd0);
`endif

    assign accept_s    = s_valid && s_ready_r;
    assign start_s     = (state_r == ST_IDLE) && accept_s;
    assign pk_clr_s    = (state_r == ST_DONE) || (state_r == ST_ERROR);
    assign hdr_last_s  = (state_r == ST_HDR) && accept_s && (pk_idx_s == 2'(HDR_BYTES - 1));
    assign data_last_s = (state_r == ST_DATA) && accept_s && (pk_idx_s == 2'(WORD_BYTES - 1));
    assign hdr_ok_s    = hdr_in_range(pk_word_s[15:0], pk_word_s[31:16], DEPTH);

    controller_rom_loader_packer u_packer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (pk_clr_s),
        .en       (accept_s),
        .byte_in  (s_data),
        .byte_idx (pk_idx_s),
        .word     (pk_word_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state selection and the error code to latch when entering ERROR.
    always_comb begin
        state_n = state_r;
        err_n_s = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_n = ST_HDR;
                else          state_n = ST_IDLE;
            end
            ST_HDR: begin
                if (abort) begin
                    state_n = ST_ERROR;
                    err_n_s = ERR_ABORT;
                end else if (hdr_last_s) begin
                    if (hdr_ok_s) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_ERROR;
                        err_n_s = ERR_HDR;
                    end
                end else begin
                    state_n = ST_HDR;
                end
            end
            ST_DATA: begin
                if (abort) begin
                    state_n = ST_ERROR;
                    err_n_s = ERR_ABORT;
                end else if (data_last_s) begin
                    state_n = ST_WRITE;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_n = ST_ERROR;
                    err_n_s = ERR_ABORT;
                end else if (remain_r == 16'd1) begin
`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
                    state_n = ST_VERIFY;
`else
                    state_n = ST_DONE;
`endif
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_VERIFY: begin
`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
                if (abort) begin
                    state_n = ST_ERROR;
                    err_n_s = ERR_ABORT;
                end else if (v_left_r == 16'd0) begin
                    if (vsum_final_s == checksum_r) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ERROR;
                        err_n_s = ERR_VERIFY;
                    end
                end else begin
                    state_n = ST_VERIFY;
                end
`else
                state_n = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERROR: begin
                if (clear) state_n = ST_IDLE;
                else       state_n = state_r;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
    // During readback the select stays high only while addresses remain to be issued.
    assign cs_n_s = (state_n == ST_WRITE) ||
                    ((state_n == ST_VERIFY) && ((state_r == ST_WRITE) || (v_left_r > 16'd1)));
`else
    assign cs_n_s = (state_n == ST_WRITE);
`endif

    // Output and datapath registers, driven from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cpu_hold_r <= 1'b0;
            err_r      <= ERR_NONE;
            checksum_r <= 32'd0;
            cs_r       <= 1'b0;
            wr_r       <= 1'b0;
            be_r       <= 4'h0;
            wdata_r    <= 32'd0;
            addr_r     <= '0;
            remain_r   <= 16'd0;
`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
            base_r     <= '0;
            count_r    <= 16'd0;
            v_left_r   <= 16'd0;
            rd_pend_r  <= 1'b0;
            vsum_r     <= 32'd0;
`endif
        end else begin
            s_ready_r <= (state_n == ST_IDLE) || (state_n == ST_HDR) || (state_n == ST_DATA);
            busy_r    <= (state_n == ST_HDR) || (state_n == ST_DATA) ||
                         (state_n == ST_WRITE) || (state_n == ST_VERIFY);
            cs_r      <= cs_n_s;
            wr_r      <= (state_n == ST_WRITE);
            be_r      <= (state_n == ST_WRITE) ? 4'hF : 4'h0;
            if (state_n == ST_WRITE) begin
                wdata_r <= pk_word_s;
            end
            if (start_s) begin
                checksum_r <= 32'd0;
                done_r     <= 1'b0;
                err_r      <= ERR_NONE;
                cpu_hold_r <= 1'b1;
            end
            if ((state_r == ST_HDR) && (state_n == ST_DATA)) begin
                addr_r   <= pk_word_s[ADDR_W-1:0];
                remain_r <= pk_word_s[31:16];
`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
                base_r   <= pk_word_s[ADDR_W-1:0];
                count_r  <= pk_word_s[31:16];
`endif
            end
            // A write strobed in the same cycle as abort still lands, so it is always summed.
            if (state_r == ST_WRITE) begin
                checksum_r <= checksum_r + wdata_r;
                addr_r     <= addr_r + ADDR_W'(1);
                remain_r   <= remain_r - 16'd1;
            end
            if ((state_n == ST_DONE) && (state_r != ST_DONE)) begin
                done_r     <= 1'b1;
                cpu_hold_r <= 1'b0;
            end
            if ((state_n == ST_ERROR) && (state_r != ST_ERROR)) begin
                err_r <= err_n_s;
            end
`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
            if ((state_r == ST_WRITE) && (state_n == ST_VERIFY)) begin
                addr_r    <= base_r;
                v_left_r  <= count_r;
                vsum_r    <= 32'd0;
                rd_pend_r <= 1'b0;
            end else if (state_r == ST_VERIFY) begin
                if (v_left_r != 16'd0) begin
                    addr_r   <= addr_r + ADDR_W'(1);
                    v_left_r <= v_left_r - 16'd1;
                end
                rd_pend_r <= (v_left_r != 16'd0);
                if (rd_pend_r) begin
                    vsum_r <= vsum_r + rom.rom_readdata;
                end
            end else begin
                rd_pend_r <= 1'b0;
            end
`endif
        end
    end

    assign s_ready            = s_ready_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign cpu_hold           = cpu_hold_r;
    assign err_code           = err_r;
    assign checksum           = checksum_r;
    assign rom.rom_address    = addr_r;
    assign rom.rom_chipselect = cs_r;
    assign rom.rom_write      = wr_r;
    assign rom.rom_byteenable = be_r;
    assign rom.rom_writedata  = wdata_r;
endmodule

// File: tb/tb_controller_rom_loader.sv
// Directed bench for controller_rom_loader: frame-level model plus a per-cycle write scoreboard.
module tb_controller_rom_loader;
    typedef struct {
        logic [12:0] a;
        logic [31:0] d;
    } wr_t;

`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        abort = 1'b0;
    logic        clear = 1'b0;
    logic        s_ready, cpu_hold, busy, done;
    logic [1:0]  err_code;
    logic [31:0] checksum;

    controller_rom_loader_if #(.ADDR_W(13)) rom();

    controller_rom_loader #(.ADDR_W(13), .DEPTH(8192)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .abort    (abort),
        .clear    (clear),
        .rom      (rom),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err_code (err_code),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, optional bit-0 corruption of the readback at 0x011.
    logic [31:0] mem [0:8191];
    logic [31:0] rd_r = 32'd0;
    bit          flip_en = 1'b0;
    always @(posedge clk) begin
        if (rom.rom_chipselect && rom.rom_write) mem[rom.rom_address] <= rom.rom_writedata;
        rd_r <= mem[rom.rom_address] ^ {31'd0, (flip_en && (rom.rom_address == 13'h011))};
    end
    assign rom.rom_readdata = rd_r;

    int          checks = 0;
    int          fails = 0;
    int          wr_cnt = 0;
    wr_t         exp_q[$];
    logic [7:0]  frm[$];
    logic [31:0] m_sum;
    logic [1:0]  m_err;
    logic        m_done, m_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // Per-cycle scoreboard of the port-2 bus against the expected write queue.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("byteenable", {28'd0, rom.rom_byteenable}, rom.rom_write ? 32'hF : 32'h0);
            if (rom.rom_write) begin
                wr_cnt++;
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("write_cs", {31'd0, rom.rom_chipselect}, 32'd1);
                    chk("write_addr", {19'd0, rom.rom_address}, {19'd0, exp_q[0].a});
                    chk("write_data", rom.rom_writedata, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Frame-level model: decode header, list the writes that must happen, final status.
    task automatic model_frame(input int nsent, input bit aborted);
        int addr, cnt;
        bit hit;
        wr_t e;
        addr = int'({frm[1], frm[0]});
        cnt  = int'({frm[3], frm[2]});
        m_sum = 32'd0; m_done = 1'b0; m_err = 2'd0; m_hold = 1'b1; hit = 1'b0;
        if (nsent < 4) begin
            if (aborted) m_err = 2'd2;
        end else if ((cnt == 0) || (addr + cnt > 8192)) begin
            m_err = 2'd1;
        end else begin
            for (int i = 0; i < cnt; i++) begin
                if (8 + 4 * i <= nsent) begin
                    e.a = 13'(addr + i);
                    e.d = {frm[4*i+7], frm[4*i+6], frm[4*i+5], frm[4*i+4]};
                    exp_q.push_back(e);
                    m_sum = m_sum + e.d;
                    if (addr + i == 17) hit = 1'b1;
                end
            end
            if (aborted) m_err = 2'd2;
            else if (VERIFY_ON && flip_en && hit) m_err = 2'd3;
            else begin
                m_done = 1'b1;
                m_hold = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data = b;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("s_ready_wait", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic run_frame(input int nsend, input bit do_abort);
        int n;
        wr_cnt = 0;
        model_frame(nsend, do_abort);
        for (int i = 0; i < nsend; i++) begin
            send_byte(frm[i]);
            if (i == 0) chk("hold_during_load", {31'd0, cpu_hold}, 32'd1);
        end
        if (do_abort) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("settle_busy", {31'd0, busy}, 32'd0);
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err_code", {30'd0, err_code}, {30'd0, m_err});
        chk("checksum", checksum, m_sum);
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_hold});
        chk("s_ready_end", {31'd0, s_ready}, 32'd0);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_ready", {31'd0, s_ready}, 32'd1);
        chk("clear_hold", {31'd0, cpu_hold}, {31'd0, m_hold});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_checksum"}, checksum, 32'd0);
        chk({tag, "_cs"}, {31'd0, rom.rom_chipselect}, 32'd0);
        chk({tag, "_write"}, {31'd0, rom.rom_write}, 32'd0);
        chk({tag, "_be"}, {28'd0, rom.rom_byteenable}, 32'd0);
        chk({tag, "_addr"}, {19'd0, rom.rom_address}, 32'd0);
        chk({tag, "_wdata"}, rom.rom_writedata, 32'd0);
    endtask

    task automatic load_valid();
        frm = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hCD, 8'hAB, 8'h89};
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", {31'd0, s_ready}, 32'd1);

        // Reference load from the test plan.
        load_valid();
        run_frame(12, 1'b0);
        chk("lit_checksum", checksum, 32'h9BE02467);
        chk("lit_mem010", mem[13'h010], 32'h12345678);
        chk("lit_mem011", mem[13'h011], 32'h89ABCDEF);
        chk("lit_hold_released", {31'd0, cpu_hold}, 32'd0);
        pulse_clear();

        frm = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(4, 1'b0);
        chk("lit_zero_err", {30'd0, err_code}, 32'd1);
        chk("lit_zero_writes", 32'(wr_cnt), 32'd0);
        pulse_clear();

        frm = '{8'hFF, 8'h1F, 8'h02, 8'h00};
        run_frame(4, 1'b0);
        chk("lit_ovf_err", {30'd0, err_code}, 32'd1);
        chk("lit_ovf_writes", 32'(wr_cnt), 32'd0);
        pulse_clear();

        // Last word of memory is a legal single-word target.
        frm = '{8'hFF, 8'h1F, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(8, 1'b0);
        chk("lit_top_mem", mem[13'h1FFF], 32'h04030201);
        pulse_clear();

        // Checksum wraps modulo 2^32.
        frm = '{8'h00, 8'h01, 8'h03, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_frame(16, 1'b0);
        chk("lit_wrap_sum", checksum, 32'h12345679);
        pulse_clear();

        frm = '{8'h20, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_frame(9, 1'b1);
        chk("lit_abort_writes", 32'(wr_cnt), 32'd1);
        chk("lit_abort_err", {30'd0, err_code}, 32'd2);
        pulse_clear();
        chk("lit_abort_hold", {31'd0, cpu_hold}, 32'd1);
        load_valid();
        run_frame(12, 1'b0);
        chk("lit_release_hold", {31'd0, cpu_hold}, 32'd0);
        pulse_clear();

        // Reset in the middle of the data phase.
        load_valid();
        for (int i = 0; i < 6; i++) send_byte(frm[i]);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(12, 1'b0);
        chk("lit_after_reset_sum", checksum, 32'h9BE02467);
        chk("lit_after_reset_done", {31'd0, done}, 32'd1);

`ifdef CONTROLLER_ROM_LOADER_VERIFY_EN
        pulse_clear();
        flip_en = 1'b1;
        load_valid();
        run_frame(12, 1'b0);
        chk("lit_verify_err", {30'd0, err_code}, 32'd3);
        chk("lit_verify_hold", {31'd0, cpu_hold}, 32'd1);
        flip_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/controller_rom_loader.md
# controller_rom_loader

Field-update loader for the controller's 8192×32 dual-port instruction memory. It accepts a framed byte stream from the host link, packs little-endian bytes into 32-bit words and writes them through the memory's second port. While a load is in progress it holds the soft CPU in reset, and it reports completion, errors and a running checksum. It sits between the host command interface and port 2 of the instruction memory; port 1 remains dedicated to the CPU fetch path.

## Interface
- ADDR_W, 13, word-address width of the instruction memory.
- DEPTH, 8192, number of words; a load must not run past DEPTH-1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_data  in  8  stream byte.
- s_valid  in  1  byte valid.
- s_ready  out  1  loader can accept a byte.
- abort  in  1  single-cycle pulse; cancels the load in progress.
- clear  in  1  single-cycle pulse; returns DONE/ERROR to IDLE.
- rom_address  out  ADDR_W  memory port-2 word address.
- rom_chipselect  out  1  port-2 select.
- rom_write  out  1  port-2 write strobe.
- rom_byteenable  out  4  fixed 4'hF while writing, otherwise 0.
- rom_writedata  out  32  word to write.
- rom_readdata  in  32  port-2 read data, valid one cycle after the address.
- cpu_hold  out  1  CPU reset request.
- busy  out  1  FSM is not in IDLE, DONE or ERROR.
- done  out  1  last load completed successfully.
- err_code  out  2  0 none, 1 bad header, 2 aborted, 3 verify mismatch.
- checksum  out  32  modulo-2^32 sum of all words written.

## Operation
- Frame format: addr[15:0] as 2 bytes LE, then count[15:0] as 2 bytes LE, then count×4 data bytes, each word LE.
- States: IDLE, HDR, DATA, WRITE, VERIFY, DONE, ERROR.
- IDLE → HDR on the first accepted byte. The same cycle clears checksum, done and err_code.
- HDR collects 4 bytes, then validates the header:
  - Reject if count == 0, or if addr + count > DEPTH (computed 17 bits wide, no wrap-around).
  - On reject: err_code = 1, ERROR, no writes.
  - On accept: go to DATA.
- DATA packs 4 bytes, then goes to WRITE.
- WRITE runs for one cycle:
  - rom_chipselect = rom_write = 1.
  - checksum += word.
  - rom_address increments.
  - Next state is DATA, or VERIFY/DONE after the last word.
- abort in HDR, DATA or WRITE → ERROR with err_code = 2. A write already strobed in that cycle completes; no further writes are issued.
- abort is ignored in IDLE, DONE and ERROR.
- clear in DONE or ERROR → IDLE. clear is ignored in other states.
- cpu_hold:
  - Asserts on the first accepted header byte.
  - Deasserts only on entry to DONE.
  - Stays asserted through ERROR and after clear from ERROR; only a successful load releases the CPU.
- Reset values: every output 0, state IDLE, s_ready 0 during reset. The initial image comes from the memory init file, so cpu_hold is 0 at reset.
- Reset mid-operation: immediate return to IDLE; a partial image is accepted as left in memory.

## Timing
- s_ready = 1 in IDLE, HDR and DATA; 0 in WRITE, VERIFY, DONE and ERROR.
- A byte transfers when s_valid & s_ready.
- The write strobe occurs on the cycle after the 4th byte of a word is accepted. Peak throughput is 4 bytes per 5 cycles.
- The memory registers its address, so read data appears one cycle after the address is presented.
- VERIFY is pipelined: one address per cycle, each readdata sampled the following cycle, count+1 cycles in total.
- done, cpu_hold release and err_code all update on the clock edge that enters DONE or ERROR.

## Configuration
- CONTROLLER_ROM_LOADER_VERIFY_EN defined:
  - After the last write, VERIFY re-reads addr..addr+count-1 and sums rom_readdata.
  - If the sum matches checksum → DONE; otherwise → ERROR with err_code = 3.
  - abort during VERIFY → ERROR with err_code = 2.
- Macro undefined:
  - The VERIFY state and its read path are omitted.
  - The last WRITE goes directly to DONE.
  - err_code 3 is never produced.

## Structure
- Package controller_rom_loader_pkg holds:
  - the state enum;
  - err_code localparams ERR_NONE, ERR_HDR, ERR_ABORT, ERR_VERIFY;
  - HDR_BYTES = 4 and WORD_BYTES = 4.
- Sub-module controller_rom_loader_packer holds the byte counter and LE shift register that assemble a 32-bit word. It is reused for the 4-byte header (addr and count fields).
- Integration ties the memory's clken2 high and drives the CPU reset request from cpu_hold.

## Test plan
- Valid load: bytes 10 00 02 00 78 56 34 12 EF CD AB 89 → 0x12345678 written at 0x010 and 0x89ABCDEF at 0x011; done = 1; checksum = 0x9BE02467; cpu_hold pulses 1 then returns to 0.
- Zero count: header 00 00 00 00 → err_code = 1, rom_write never asserted, cpu_hold = 1.
- Range overflow: header FF 1F 02 00 (addr 0x1FFF, count 2) → err_code = 1, no write.
- Abort after 5 data bytes of a count-4 load → exactly one write, err_code = 2, s_ready = 0. clear → IDLE with cpu_hold still 1; a following valid load releases it.
- VERIFY_EN: memory model flips bit 0 of the readback at 0x011 in the valid-load case → err_code = 3, cpu_hold stays 1.
- reset_n low while in DATA → all outputs 0 asynchronously; after release, the valid-load case passes unchanged.
